// File: rtl/go_done_initiator_pkg.sv
// Shared definitions for the go/doneSig requester: state encodings and
// default timing derived from the responder's clock divider.
package go_done_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ASSERT    = 2'b01,
        ST_WAIT_DONE = 2'b10,
        ST_ERR       = 2'b11
    } state_e;

    // Responder toggles its divided clock every RESP_DIV board clocks.
    localparam int RESP_DIV        = 600000;
    localparam int RESP_DIV_FACTOR = 2;
    localparam int RESP_PERIOD     = RESP_DIV * RESP_DIV_FACTOR;

    // Hold go for two responder periods so it is sampled at least once.
    localparam int DEFAULT_HOLD_CYCLES    = 2 * RESP_PERIOD;
    localparam int DEFAULT_TIMEOUT_CYCLES = 3 * RESP_PERIOD;

    localparam int LED_W = 4;

endpackage

// File: rtl/go_done_initiator_sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector; one-clk pulse
// per low-to-high transition of an asynchronous input.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/go_done_initiator.sv
// Requester end of the go/doneSig handshake: holds go long enough for the
// slow responder, waits for doneSig with a timeout, counts completions on LEDs.
module go_done_initiator
    import go_done_initiator_pkg::*;
#(
    parameter int HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startReq,
    input  logic             clearErr,
    input  logic             doneSig,
    output logic             go,
    output logic             busy,
    output logic             doneOut,
    output logic             timeoutErr,
    output logic [LED_W-1:0] led
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [LED_W-1:0] LED_ONE      = LED_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               go_q, go_d;
    logic               busy_q, busy_d;
    logic               done_out_q, done_out_d;
    logic               err_q, err_d;
    logic               done_rise;

    sync_edge_detect u_done_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (doneSig),
        .rise_o  (done_rise)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        led_d      = led_q;
        done_out_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (startReq) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                // done edges are meaningless until go has fallen
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_DONE: begin
                // a done edge on the last timeout cycle still completes cleanly
                if (done_rise) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    led_d      = led_q + LED_ONE;
                    done_out_d = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_ERR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ERR: begin
                cnt_d = '0;
                if (clearErr) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        go_d   = (state_d == ST_ASSERT);
        busy_d = (state_d == ST_ASSERT) || (state_d == ST_WAIT_DONE);
        err_d  = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            led_q      <= '0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_out_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
            go_q       <= go_d;
            busy_q     <= busy_d;
            done_out_q <= done_out_d;
            err_q      <= err_d;
        end
    end

    assign go         = go_q;
    assign busy       = busy_q;
    assign doneOut    = done_out_q;
    assign timeoutErr = err_q;
    assign led        = led_q;

endmodule

// File: tb/tb_go_done_initiator.sv
// Directed self-checking bench for go_done_initiator with HOLD_CYCLES=4,
// TIMEOUT_CYCLES=10; outputs are sampled 1 time unit after each rising edge.
module tb_go_done_initiator;

    localparam int HOLD    = 4;
    localparam int TIMEOUT = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       startReq;
    logic       clearErr;
    logic       doneSig;
    logic       go;
    logic       busy;
    logic       doneOut;
    logic       timeoutErr;
    logic [3:0] led;

    int n_pass  = 0;
    int n_total = 0;
    int done_seen = 0;

    go_done_initiator #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (22)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .startReq   (startReq),
        .clearErr   (clearErr),
        .doneSig    (doneSig),
        .go         (go),
        .busy       (busy),
        .doneOut    (doneOut),
        .timeoutErr (timeoutErr),
        .led        (led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (doneOut === 1'b1) done_seen++;
        end
    endtask

    // One normal transaction; doneSig pulses one clk right after go falls.
    task automatic run_txn();
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        tick(HOLD);
        doneSig = 1'b1;
        tick();
        doneSig = 1'b0;
        tick(4);
    endtask

    initial begin
        rst      = 1'b1;
        startReq = 1'b0;
        clearErr = 1'b0;
        doneSig  = 1'b0;
        tick(2);
        check("reset_go",   go,         1'b0);
        check("reset_busy", busy,       1'b0);
        check("reset_done", doneOut,    1'b0);
        check("reset_err",  timeoutErr, 1'b0);
        check("reset_led",  led,        4'd0);
        rst = 1'b0;
        tick();

        // Basic transaction: go high for exactly HOLD clocks
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        check("basic_go_rise", go,   1'b1);
        check("basic_busy",    busy, 1'b1);
        tick(HOLD - 1);
        check("basic_go_last", go, 1'b1);
        tick();
        check("basic_go_fall",   go,   1'b0);
        check("basic_busy_wait", busy, 1'b1);
        tick(2);
        doneSig = 1'b1;
        tick(2);
        check("basic_done_early", doneOut, 1'b0);
        doneSig = 1'b0;
        tick();
        check("basic_done_pulse", doneOut, 1'b1);
        check("basic_led",        led,     4'd1);
        check("basic_busy_low",   busy,    1'b0);
        tick();
        check("basic_done_once", doneOut, 1'b0);

        // Early done during ASSERT is ignored, then timeout
        done_seen = 0;
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        doneSig = 1'b1;
        tick();
        doneSig = 1'b0;
        tick(HOLD - 1);
        check("to_go_fall", go, 1'b0);
        tick(TIMEOUT - 1);
        check("to_not_yet", timeoutErr, 1'b0);
        check("to_busy_wait", busy, 1'b1);
        tick();
        check("to_err",        timeoutErr, 1'b1);
        check("to_busy_low",   busy,       1'b0);
        check("to_led_hold",   led,        4'd1);
        check("early_no_done", done_seen,  0);

        // Late done in ERR discarded; startReq ignored in ERR
        doneSig = 1'b1;
        tick();
        doneSig = 1'b0;
        startReq = 1'b1;
        tick(4);
        startReq = 1'b0;
        check("late_no_done", done_seen,  0);
        check("late_led",     led,        4'd1);
        check("err_no_go",    go,         1'b0);
        check("err_held",     timeoutErr, 1'b1);
        clearErr = 1'b1;
        tick();
        clearErr = 1'b0;
        check("clear_err",  timeoutErr, 1'b0);
        check("clear_busy", busy,       1'b0);

        // New start accepted; done edge coincides with counter==TIMEOUT-1
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        check("restart_go", go, 1'b1);
        tick(HOLD);
        tick(TIMEOUT - 3);
        doneSig = 1'b1;
        tick();
        doneSig = 1'b0;
        tick();
        check("sim_pre_done", doneOut,    1'b0);
        check("sim_pre_err",  timeoutErr, 1'b0);
        tick();
        check("sim_done",     doneOut,    1'b1);
        check("sim_no_err",   timeoutErr, 1'b0);
        check("sim_led",      led,        4'd2);
        check("sim_busy_low", busy,       1'b0);
        tick();
        check("sim_idle_err", timeoutErr, 1'b0);

        // LED wrap over 16 transactions
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wrap_reset_led", led, 4'd0);
        for (int i = 0; i < 15; i++) begin
            done_seen = 0;
            run_txn();
            check("wrap_one_done", done_seen, 1);
        end
        check("wrap_led_15", led, 4'd15);
        done_seen = 0;
        run_txn();
        check("wrap_led_0",   led,       4'd0);
        check("wrap_last_done", done_seen, 1);

        // Held startReq: back-to-back with exactly one IDLE clock
        startReq = 1'b1;
        tick();
        check("held_go1", go, 1'b1);
        tick(HOLD);
        doneSig = 1'b1;
        tick();
        doneSig = 1'b0;
        tick();
        check("held_wait_busy", busy, 1'b1);
        tick();
        check("held_done",      doneOut, 1'b1);
        check("held_idle_go",   go,      1'b0);
        check("held_idle_busy", busy,    1'b0);
        tick();
        check("held_go2",   go,   1'b1);
        check("held_busy2", busy, 1'b1);
        check("held_led",   led,  4'd1);

        // Reset mid-ASSERT
        tick();
        rst = 1'b1;
        tick();
        check("midrst_go",   go,         1'b0);
        check("midrst_busy", busy,       1'b0);
        check("midrst_led",  led,        4'd0);
        check("midrst_err",  timeoutErr, 1'b0);
        rst = 1'b0;
        startReq = 1'b0;
        tick();
        check("midrst_idle", go, 1'b0);
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        check("midrst_restart", go, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
